// File: rtl/alu_iterative.sv
// RV32I execution-stage ALU. Single-cycle add/sub/compare/logic/lui;
// shifts are performed one bit per cycle to avoid a barrel shifter,
// with a valid/ready handshake so the pipeline can stall meanwhile.
module alu_iterative #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic [4:0]      iv_AluOp,
  input  logic [XLEN-1:0] iv_A,
  input  logic [XLEN-1:0] iv_B,
  output logic            o_valid,
  output logic [XLEN-1:0] ov_result,
  output logic            o_zero,
  output logic            o_illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10100;
  localparam logic [4:0] OP_SRA  = 5'b10110;
  localparam logic [4:0] OP_OR   = 5'b11000;
  localparam logic [4:0] OP_AND  = 5'b11100;
  localparam logic [4:0] OP_BGE  = 5'b11010;
  localparam logic [4:0] OP_BGEU = 5'b11110;
  localparam logic [4:0] OP_LUI  = 5'b11101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Single-cycle result; MSB is the illegal-opcode flag. Shift opcodes
  // return A unchanged, which is the correct answer for a zero shift.
  function automatic logic [XLEN:0] alu_eval(input logic [4:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu_eval = {1'b0, a + b};
      OP_SUB:  alu_eval = {1'b0, a - b};
      OP_SLT:  alu_eval = {1'b0, XLEN'(sa < sb)};
      OP_SLTU: alu_eval = {1'b0, XLEN'(a < b)};
      OP_XOR:  alu_eval = {1'b0, a ^ b};
      OP_OR:   alu_eval = {1'b0, a | b};
      OP_AND:  alu_eval = {1'b0, a & b};
      OP_BGE:  alu_eval = {1'b0, XLEN'(sa >= sb)};
      OP_BGEU: alu_eval = {1'b0, XLEN'(a >= b)};
      OP_LUI:  alu_eval = {1'b0, b};
      OP_SLL, OP_SRL, OP_SRA: alu_eval = {1'b0, a};
      default: alu_eval = {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  // One-bit shift step for the iterative shifter.
  function automatic logic [XLEN-1:0] shift1(input logic [4:0] op,
                                             input logic [XLEN-1:0] w);
    case (op)
      OP_SLL:  shift1 = {w[XLEN-2:0], 1'b0};
      OP_SRA:  shift1 = {w[XLEN-1], w[XLEN-1:1]};
      default: shift1 = {1'b0, w[XLEN-1:1]};
    endcase
  endfunction

  logic [1:0]      state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] work;
  logic [4:0]      op_q;
  logic [XLEN:0]   alu_res;
  logic [XLEN-1:0] shifted;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            accept;

  assign shamt    = iv_B[SHW-1:0];
  assign is_shift = (iv_AluOp == OP_SLL) || (iv_AluOp == OP_SRL) ||
                    (iv_AluOp == OP_SRA);
  assign accept   = (state == ST_IDLE) && i_valid && !i_flush;
  assign alu_res  = alu_eval(iv_AluOp, iv_A, iv_B);
  assign shifted  = shift1(op_q, work);
  assign o_ready  = (state == ST_IDLE);
  assign o_valid  = (state == ST_DONE) && !i_flush;

  // Control FSM and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ov_result <= '0;
      o_zero    <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              cnt   <= shamt;
              state <= ST_SHIFT;
            end else begin
              ov_result <= alu_res[XLEN-1:0];
              o_zero    <= (alu_res[XLEN-1:0] == '0);
              o_illegal <= alu_res[XLEN];
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (i_flush) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == SHW'(1)) begin
            ov_result <= shifted;
            o_zero    <= (shifted == '0);
            o_illegal <= 1'b0;
            cnt       <= '0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift working register and latched opcode (datapath, no reset needed).
  always_ff @(posedge i_clk) begin
    if (accept) begin
      work <= iv_A;
      op_q <= iv_AluOp;
    end else if (state == ST_SHIFT) begin
      work <= shifted;
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed testbench for alu_iterative.
module tb_alu_iterative;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic [4:0]  aluop;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        o_valid;
  logic [31:0] ov_result;
  logic        o_zero;
  logic        o_illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_iterative #(.XLEN(32), .SHW(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .iv_AluOp(aluop), .iv_A(a_in), .iv_B(b_in),
    .o_valid(o_valid), .ov_result(ov_result), .o_zero(o_zero),
    .o_illegal(o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for one clock; returns at the negedge of cycle 1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_valid = 1'b1; aluop = op; a_in = a; b_in = b;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; aluop = '0; a_in = '0; b_in = '0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    n_cmp++; if (ov_result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", ov_result); end
    n_cmp++; if (o_zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", o_zero); end
    n_cmp++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", o_illegal); end
    rst = 1'b0;
  endtask

  task automatic test_add_sub;
    issue(5'b00000, 32'd5, 32'd7);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%b exp=1", o_valid); end
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL add_ready got=%b exp=0", o_ready); end
    n_cmp++; if (ov_result !== 32'd12) begin n_err++; $display("FAIL add_result got=%h exp=c", ov_result); end
    n_cmp++; if (o_zero !== 1'b0) begin n_err++; $display("FAIL add_zero got=%b exp=0", o_zero); end
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse got=%b exp=0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL add_idle got=%b exp=1", o_ready); end
    issue(5'b00010, 32'h10, 32'h10);
    n_cmp++; if (ov_result !== 32'h0) begin n_err++; $display("FAIL sub_result got=%h exp=0", ov_result); end
    n_cmp++; if (o_zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got=%b exp=1", o_zero); end
  endtask

  task automatic test_shift;
    issue(5'b10110, 32'h8000_0000, 32'd4);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL sra_ready c=%0d got=%b exp=0", c, o_ready); end
      n_cmp++; if (o_valid !== (c == 5)) begin n_err++; $display("FAIL sra_valid c=%0d got=%b exp=%b", c, o_valid, (c == 5)); end
    end
    n_cmp++; if (ov_result !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result got=%h exp=f8000000", ov_result); end
    @(negedge clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL sra_idle got=%b exp=1", o_ready); end
    issue(5'b10100, 32'h8000_0000, 32'd4);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      n_cmp++; if (o_valid !== (c == 5)) begin n_err++; $display("FAIL srl_valid c=%0d got=%b exp=%b", c, o_valid, (c == 5)); end
    end
    n_cmp++; if (ov_result !== 32'h0800_0000) begin n_err++; $display("FAIL srl_result got=%h exp=08000000", ov_result); end
  endtask

  task automatic test_compare;
    issue(5'b01000, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (ov_result !== 32'd1) begin n_err++; $display("FAIL slt got=%h exp=1", ov_result); end
    issue(5'b01100, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (ov_result !== 32'd0) begin n_err++; $display("FAIL sltu got=%h exp=0", ov_result); end
    issue(5'b11010, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (ov_result !== 32'd0) begin n_err++; $display("FAIL bge got=%h exp=0", ov_result); end
    issue(5'b11110, 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (ov_result !== 32'd1) begin n_err++; $display("FAIL bgeu got=%h exp=1", ov_result); end
    issue(5'b10000, 32'd3, 32'd3);
    n_cmp++; if (o_zero !== 1'b1) begin n_err++; $display("FAIL bne_zero got=%b exp=1", o_zero); end
    issue(5'b11000, 32'hF0F0_0000, 32'h0000_0F0F);
    n_cmp++; if (ov_result !== 32'hF0F0_0F0F) begin n_err++; $display("FAIL or got=%h exp=f0f00f0f", ov_result); end
    issue(5'b11100, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_cmp++; if (ov_result !== 32'h0F00_0F00) begin n_err++; $display("FAIL and got=%h exp=0f000f00", ov_result); end
  endtask

  task automatic test_boundary;
    issue(5'b00100, 32'h1, 32'd32);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL sll32_valid got=%b exp=1", o_valid); end
    n_cmp++; if (ov_result !== 32'h1) begin n_err++; $display("FAIL sll32_result got=%h exp=1", ov_result); end
    issue(5'b11101, 32'hDEAD_BEEF, 32'h1234_5000);
    n_cmp++; if (ov_result !== 32'h1234_5000) begin n_err++; $display("FAIL lui got=%h exp=12345000", ov_result); end
    n_cmp++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL lui_illegal got=%b exp=0", o_illegal); end
    issue(5'b11111, 32'h5, 32'h6);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got=%b exp=1", o_valid); end
    n_cmp++; if (o_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", o_illegal); end
    n_cmp++; if (ov_result !== 32'h0) begin n_err++; $display("FAIL ill_result got=%h exp=0", ov_result); end
    issue(5'b00001, 32'h5, 32'h6);
    n_cmp++; if (o_illegal !== 1'b1) begin n_err++; $display("FAIL ill2_flag got=%b exp=1", o_illegal); end
  endtask

  task automatic test_flush;
    logic seen;
    issue(5'b00000, 32'd1, 32'd2);
    n_cmp++; if (ov_result !== 32'd3) begin n_err++; $display("FAIL pre_flush got=%h exp=3", ov_result); end
    issue(5'b10100, 32'hFFFF_0000, 32'd20);
    @(negedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_c3_valid got=%b exp=0", o_valid); end
    @(negedge clk);
    i_flush = 1'b0;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
    n_cmp++; if (ov_result !== 32'd3) begin n_err++; $display("FAIL flush_result got=%h exp=3", ov_result); end
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (o_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
    i_valid = 1'b1; i_flush = 1'b1; aluop = 5'b00000; a_in = 32'd10; b_in = 32'd10;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL idleflush_valid got=%b exp=0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL idleflush_ready got=%b exp=1", o_ready); end
    n_cmp++; if (ov_result !== 32'd3) begin n_err++; $display("FAIL idleflush_result got=%h exp=3", ov_result); end
  endtask

  task automatic test_reset_midshift;
    issue(5'b00100, 32'h1, 32'd31);
    repeat (4) @(negedge clk);
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL midshift_busy got=%b exp=0", o_ready); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", o_valid); end
    n_cmp++; if (ov_result !== 32'h0) begin n_err++; $display("FAIL arst_result got=%h exp=0", ov_result); end
    n_cmp++; if (o_zero !== 1'b0) begin n_err++; $display("FAIL arst_zero got=%b exp=0", o_zero); end
    @(negedge clk);
    rst = 1'b0;
    issue(5'b00000, 32'd4, 32'd5);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid got=%b exp=1", o_valid); end
    n_cmp++; if (ov_result !== 32'd9) begin n_err++; $display("FAIL post_rst_result got=%h exp=9", ov_result); end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_shift;
    test_compare;
    test_boundary;
    test_flush;
    test_reset_midshift;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
